// File: rtl/fp_pkg.sv
// Shared FP32 field layout, FSM state encoding and special-value constants
// for the sequential single-precision subtractor.
package fp_pkg;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int MANT_W   = 23;
   localparam int EXP_BIAS = 127;
   localparam int EXP_MAX  = 255;

   localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ALIGN = 3'd1,
      ARITH = 3'd2,
      NORM  = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/fp_subtractor_seq_if.sv
// Operand (valid/ready) and result (valid/ready) channels of the FP subtractor.
// master = producer of operands and consumer of results; slave = the subtractor.
interface fp_subtractor_seq_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, result
   );

endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
   parameter int W = 28
) (
   input  logic [W-1:0]       value,
   output logic [$clog2(W):0] count
);

   localparam int CW = $clog2(W) + 1;

   // Later (higher) set bits overwrite earlier ones, so the MSB-most one wins.
   always_comb begin
      count = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (value[i]) begin
            count = CW'(W - 1 - i);
         end
      end
   end

endmodule

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (A - B), truncating rounding,
// denormals flushed to zero, one operation in flight at a time.
module fp_subtractor_seq
   import fp_pkg::*;
#(
   parameter int GUARD_BITS = 3
) (
   input logic                clk,
   input logic                rst,
   fp_subtractor_seq_if.slave bus
);

   localparam int W   = 24 + GUARD_BITS + 1;
   localparam int LZW = $clog2(W) + 1;
   localparam logic [7:0]        SHIFT_LIMIT = 8'(24 + GUARD_BITS);
   localparam logic signed [9:0] EXP_MAX_S   = 10'(EXP_MAX);

   state_t      state_reg, state_next;
   logic [31:0] a_reg, b_reg, result_reg;
   logic [W-1:0] m_l_reg, m_s_reg, sum_reg;
   logic [7:0]  exp_l_reg;
   logic        a_ge_b_reg, sign_reg;
   logic        in_ready, out_valid;

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.in_valid) state_next = ALIGN;
         ALIGN:   state_next = ARITH;
         ARITH:   state_next = NORM;
         NORM:    state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE);
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.result    = result_reg;

   // Alignment: an exponent of zero makes the whole operand zero.
   logic [7:0]   exp_a, exp_b, exp_l, exp_s, exp_diff;
   logic [30:0]  key_a, key_b;
   logic [23:0]  sig_a, sig_b, sig_l, sig_s;
   logic         a_ge_b;
   logic [W-1:0] sig_l_ext, sig_s_ext, sig_s_shifted;

   always_comb begin
      exp_a         = a_reg[EXP_MSB:EXP_LSB];
      exp_b         = b_reg[EXP_MSB:EXP_LSB];
      key_a         = (exp_a == 8'd0) ? '0 : a_reg[EXP_MSB:0];
      key_b         = (exp_b == 8'd0) ? '0 : b_reg[EXP_MSB:0];
      sig_a         = (exp_a == 8'd0) ? '0 : {1'b1, a_reg[MANT_W-1:0]};
      sig_b         = (exp_b == 8'd0) ? '0 : {1'b1, b_reg[MANT_W-1:0]};
      a_ge_b        = (key_a >= key_b);
      sig_l         = a_ge_b ? sig_a : sig_b;
      sig_s         = a_ge_b ? sig_b : sig_a;
      exp_l         = a_ge_b ? exp_a : exp_b;
      exp_s         = a_ge_b ? exp_b : exp_a;
      exp_diff      = exp_l - exp_s;
      sig_l_ext     = {1'b0, sig_l, {GUARD_BITS{1'b0}}};
      sig_s_ext     = {1'b0, sig_s, {GUARD_BITS{1'b0}}};
      sig_s_shifted = (exp_diff >= SHIFT_LIMIT) ? '0 : (sig_s_ext >> exp_diff);
   end

   // Normalization of the raw sum; bit W-1 is the carry, bit W-2 the implicit one.
   logic [LZW-1:0]     lzc;
   logic [W-1:0]       norm_mag;
   logic signed [9:0]  exp_norm;
   logic [31:0]        norm_result;
   logic               unused_bits;

   fp_lzc #(.W(W)) u_lzc (
      .value (sum_reg),
      .count (lzc)
   );

   always_comb begin
      exp_norm = $signed({2'b00, exp_l_reg});
      if (sum_reg[W-1]) begin
         norm_mag = sum_reg >> 1;
         exp_norm = exp_norm + 10'sd1;
      end else begin
         norm_mag = sum_reg << (lzc - 1'b1);
         exp_norm = exp_norm - $signed(10'(lzc)) + 10'sd1;
      end
      if (sum_reg == '0)
         norm_result = FP_POS_ZERO;
      else if (exp_norm >= EXP_MAX_S)
         norm_result = {sign_reg, FP_POS_INF[30:0]};
      else if (exp_norm <= 10'sd0)
         norm_result = {sign_reg, 31'h0};
      else
         norm_result = {sign_reg, exp_norm[7:0], norm_mag[W-3 -: MANT_W]};
   end

   assign unused_bits = ^{norm_mag[W-1:W-2], norm_mag[GUARD_BITS-1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         m_l_reg    <= '0;
         m_s_reg    <= '0;
         sum_reg    <= '0;
         exp_l_reg  <= '0;
         a_ge_b_reg <= 1'b0;
         sign_reg   <= 1'b0;
         result_reg <= FP_POS_ZERO;
      end else begin
         case (state_reg)
            IDLE: if (bus.in_valid) begin
               a_reg <= bus.A;
               b_reg <= bus.B;
            end
            ALIGN: begin
               m_l_reg    <= sig_l_ext;
               m_s_reg    <= sig_s_shifted;
               exp_l_reg  <= exp_l;
               a_ge_b_reg <= a_ge_b;
            end
            ARITH: begin
               // Equal signs mean the magnitudes really subtract.
               sum_reg  <= (a_reg[SIGN_BIT] == b_reg[SIGN_BIT]) ? (m_l_reg - m_s_reg)
                                                                : (m_l_reg + m_s_reg);
               sign_reg <= a_ge_b_reg ? a_reg[SIGN_BIT] : ~b_reg[SIGN_BIT];
            end
            NORM:    result_reg <= norm_result;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Scoreboard bench for fp_subtractor_seq: directed vectors, handshake/reset
// scenarios and randomized operands against an arithmetic reference model.
module tb_fp_subtractor_seq;

   localparam int G = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fp_subtractor_seq_if ifc();

   fp_subtractor_seq #(.GUARD_BITS(G)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   int          acc_q[$];
   int          acc_log[$];
   int          negcnt  = 0;
   int          or_mode = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Reference: exact integer significands, aligned with truncation, then normalized.
   function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
      int     ea = int'(a[30:23]);
      int     eb = int'(b[30:23]);
      longint ka = (ea == 0) ? 0 : longint'(a[30:0]);
      longint kb = (eb == 0) ? 0 : longint'(b[30:0]);
      longint sa = (ea == 0) ? 0 : (longint'(a[22:0]) + 64'h80_0000);
      longint sb = (eb == 0) ? 0 : (longint'(b[22:0]) + 64'h80_0000);
      bit     ge = (ka >= kb);
      int     el = ge ? ea : eb;
      int     es = ge ? eb : ea;
      longint ml = (ge ? sa : sb) << G;
      longint ms = (ge ? sb : sa) << G;
      longint r;
      bit     s;
      int     e;
      ms = ((el - es) >= 24 + G) ? 0 : (ms >> (el - es));
      r  = (a[31] == b[31]) ? (ml - ms) : (ml + ms);
      s  = ge ? a[31] : ~b[31];
      e  = el;
      if (r == 0) return 32'h0;
      while (r >= (64'd1 << (24 + G))) begin r = r >> 1; e++; end
      while (r <  (64'd1 << (23 + G))) begin r = r << 1; e--; end
      if (e >= 255) return {s, 8'hFF, 23'h0};
      if (e <= 0)   return {s, 31'h0};
      return {s, 8'(e), 23'(r >> G)};
   endfunction

   // Monitor: latency from accept to out_valid and result scoreboard.
   initial begin
      int a;
      bit prev_ov;
      prev_ov = 1'b0;
      forever begin
         @(negedge clk);
         negcnt++;
         if (!rst) begin
            if (ifc.in_valid && ifc.in_ready) begin
               acc_q.push_back(negcnt);
               acc_log.push_back(negcnt);
            end
            if (ifc.out_valid && !prev_ov) begin
               if (acc_q.size() == 0) check("latency_no_accept", 32'd1, 32'd0);
               else begin
                  a = acc_q.pop_front();
                  check("latency", 32'(negcnt - a), 32'd4);
               end
            end
            if (ifc.out_valid && ifc.out_ready) begin
               if (exp_q.size() == 0) check("spurious_result", 32'd1, 32'd0);
               else check("result", ifc.result, exp_q.pop_front());
            end
         end
         prev_ov = ifc.out_valid;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (or_mode)
            0:       ifc.out_ready = 1'b1;
            1:       ifc.out_ready = ($urandom % 3 != 0);
            default: ifc.out_ready = 1'b0;
         endcase
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // Called #1 after a rising edge; returns #1 after the accept edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
      int guard = 0;
      while (!ifc.in_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!ifc.in_ready) begin
         check("in_ready_timeout", 32'd0, 32'd1);
         return;
      end
      ifc.A = a;
      ifc.B = b;
      ifc.in_valid = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      ifc.in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   logic [31:0] dir_a[8] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                             32'h40000000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF};
   logic [31:0] dir_b[8] = '{32'h3F800000, 32'h3F800000, 32'h3F7FFFFF, 32'hBF800000,
                             32'hC0400000, 32'h40400000, 32'h30800000, 32'hFF7FFFFF};
   logic [31:0] dir_r[8] = '{32'h40000000, 32'h00000000, 32'h33800000, 32'h40000000,
                             32'h40A00000, 32'hC0000000, 32'h3F800000, 32'h7F800000};

   initial begin
      int          e1, e2, guard;
      logic [31:0] m1, m2, a, b;
      bit          s1, s2;

      rst = 1'b1;
      ifc.in_valid = 1'b0;
      ifc.A = '0;
      ifc.B = '0;
      ifc.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", 32'(ifc.in_ready), 32'd1);
      check("reset_out_valid", 32'(ifc.out_valid), 32'd0);
      check("reset_result", ifc.result, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) issue(dir_a[i], dir_b[i], dir_r[i]);
      drain();

      // Stall downstream; result must hold and busy in_valid pulses be ignored.
      or_mode = 2;
      @(posedge clk); #1;
      issue(32'h40400000, 32'h3F800000, 32'h40000000);
      guard = 0;
      while (!ifc.out_valid && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      for (int i = 0; i < 5; i++) begin
         ifc.in_valid = i[0];
         ifc.A = 32'h3F800000;
         ifc.B = 32'hC1200000;
         @(posedge clk); #1;
         check("hold_out_valid", 32'(ifc.out_valid), 32'd1);
         check("hold_result", ifc.result, 32'h40000000);
         check("hold_in_ready", 32'(ifc.in_ready), 32'd0);
      end
      ifc.in_valid = 1'b0;
      or_mode = 0;
      drain();

      // Back-to-back throughput.
      acc_log.delete();
      for (int i = 0; i < 4; i++) issue(dir_a[i+3], dir_b[i+3], dir_r[i+3]);
      drain();
      for (int i = 1; i < acc_log.size(); i++)
         check("throughput", 32'(acc_log[i] - acc_log[i-1]), 32'd5);

      // Reset while in ARITH aborts the op.
      issue(32'h40000000, 32'hC0400000, 32'h40A00000);
      @(posedge clk); #1;
      rst = 1'b1;
      void'(exp_q.pop_back());
      void'(acc_q.pop_back());
      @(posedge clk); #1;
      check("abort_out_valid", 32'(ifc.out_valid), 32'd0);
      check("abort_in_ready", 32'(ifc.in_ready), 32'd1);
      rst = 1'b0;
      issue(32'h3F800000, 32'h40400000, 32'hC0000000);
      drain();

      // Randomized operands with random downstream stalls.
      or_mode = 1;
      for (int i = 0; i < 60; i++) begin
         s1 = 1'($urandom);
         s2 = 1'($urandom);
         e1 = ($urandom % 10 == 0) ? 0 : int'($urandom_range(1, 254));
         m1 = $urandom & 32'h7FFFFF;
         m2 = $urandom & 32'h7FFFFF;
         case ($urandom % 3)
            0: e2 = ($urandom % 10 == 0) ? 0 : int'($urandom_range(1, 254));
            1: e2 = e1 + int'($urandom_range(0, 6)) - 3;
            default: begin
               e2 = e1;
               m2 = m1 ^ ($urandom % 16);
            end
         endcase
         if (e2 < 0)   e2 = 0;
         if (e2 > 254) e2 = 254;
         a = {s1, 8'(e1), m1[22:0]};
         b = {s2, 8'(e2), m2[22:0]};
         issue(a, b, ref_sub(a, b));
      end
      or_mode = 0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
